temporal_encoder: RTL and testbench

- Converts binary values into race-logic temporal signals, one channel per lane, within fixed-length gamma cycles.
- It is the producer for the edge-comparison blocks (less_than and related) and drives their data inputs and their set/reset pulse.
- It generates rising-edge, falling-edge and pulse-width encodings simultaneously, so any comparator flavour can be fed.
- Binary vectors arrive over a valid/ready handshake and are buffered one deep, so gamma cycles run back-to-back.

---
 rtl/temporal_encoder.sv | 149 ++++++++++++++
 tb/tb_temporal_encoder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/temporal_encoder.sv
// Race-logic temporal encoder: binary lane values become rising-edge,
// falling-edge and pulse encodings inside back-to-back gamma cycles.
module temporal_encoder #(
    parameter int GAMMA_CYCLE_WIDTH = 16,
    parameter int PULSE_WIDTH       = 8,
    parameter int LANES             = 2,
    parameter int VAL_W             = $clog2(GAMMA_CYCLE_WIDTH) + 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [LANES*VAL_W-1:0]               in_value,
    output logic                                 gamma_set,
    output logic [LANES-1:0]                     edge_rise,
    output logic [LANES-1:0]                     edge_fall,
    output logic [LANES-1:0]                     pulse,
    output logic                                 busy,
    output logic [$clog2(GAMMA_CYCLE_WIDTH)-1:0] gamma_idx
);

    localparam int IW = $clog2(GAMMA_CYCLE_WIDTH);
    localparam int DW = LANES * VAL_W;
    localparam logic [IW-1:0] LAST = IW'(GAMMA_CYCLE_WIDTH - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   pend_q, pend_d;
    logic            pend_full_q, pend_full_d;
    logic [DW-1:0]   act_q, act_d;
    logic            rdy_q;

    logic            set_q, set_d;
    logic            busy_q, busy_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [LANES-1:0] rise_q, rise_d;
    logic [LANES-1:0] fall_q, fall_d;
    logic [LANES-1:0] pulse_q, pulse_d;

    logic            accept;
    logic            launch;
    logic            run_d;
    logic [31:0]     c_d;

    // rdy_q keeps in_ready low until the first edge after reset release
    assign in_ready = rdy_q && !pend_full_q;
    assign accept   = in_valid && in_ready;
    assign launch   = pend_full_q && (state_q == IDLE || cnt_q == LAST);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        act_d       = act_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;

        if (accept) begin
            pend_d      = in_value;
            pend_full_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (launch) begin
                    state_d     = RUN;
                    cnt_d       = '0;
                    act_d       = pend_q;
                    pend_full_d = 1'b0;
                end
            end
            RUN: begin
                if (launch) begin
                    cnt_d       = '0;
                    act_d       = pend_q;
                    pend_full_d = 1'b0;
                end else if (cnt_q == LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are derived from next state so they register in step with it
    assign run_d  = (state_d == RUN);
    assign c_d    = 32'(cnt_d);
    assign set_d  = run_d && (cnt_d == '0);
    assign busy_d = run_d;
    assign idx_d  = run_d ? cnt_d : '0;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [31:0] t;
        logic [31:0] t_end;
        assign t     = 32'(act_d[i*VAL_W +: VAL_W]);
        assign t_end = t + 32'(PULSE_WIDTH);
        assign rise_d[i]  = run_d && (c_d >= t);
        assign fall_d[i]  = run_d && (c_d < t);
        assign pulse_d[i] = run_d && (c_d >= t) && (c_d < t_end);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            act_q       <= '0;
            rdy_q       <= 1'b0;
            set_q       <= 1'b0;
            busy_q      <= 1'b0;
            idx_q       <= '0;
            rise_q      <= '0;
            fall_q      <= '0;
            pulse_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            act_q       <= act_d;
            rdy_q       <= 1'b1;
            set_q       <= set_d;
            busy_q      <= busy_d;
            idx_q       <= idx_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
            pulse_q     <= pulse_d;
        end
    end

    assign gamma_set = set_q;
    assign busy      = busy_q;
    assign gamma_idx = idx_q;
    assign edge_rise = rise_q;
    assign edge_fall = fall_q;
    assign pulse     = pulse_q;

endmodule

// File: tb/tb_temporal_encoder.sv
// Scoreboard bench for temporal_encoder: accepted vectors are queued and
// every cycle's outputs are checked against the gamma-cycle timing model.
module tb_temporal_encoder;

    localparam int G  = 16;
    localparam int PW = 8;
    localparam int L  = 2;
    localparam int VW = 5;
    localparam int IW = 4;
    localparam int DW = L * VW;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_value;
    logic          gamma_set;
    logic [L-1:0]  edge_rise;
    logic [L-1:0]  edge_fall;
    logic [L-1:0]  pulse;
    logic          busy;
    logic [IW-1:0] gamma_idx;

    always #5 clk = ~clk;

    temporal_encoder #(
        .GAMMA_CYCLE_WIDTH(G),
        .PULSE_WIDTH      (PW),
        .LANES            (L),
        .VAL_W            (VW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_value (in_value),
        .gamma_set(gamma_set),
        .edge_rise(edge_rise),
        .edge_fall(edge_fall),
        .pulse    (pulse),
        .busy     (busy),
        .gamma_idx(gamma_idx)
    );

    typedef struct packed {
        logic [31:0]   a;
        logic [DW-1:0] v;
    } ent_t;

    ent_t q[$];
    ent_t cur;
    int   cyc;
    int   s_cyc;
    int   checks;
    int   errors;
    int   n_acc;
    int   n_start;
    bit   act;
    bit   acc_seen;
    bit   was_rst;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic monitor();
        logic [L-1:0] er;
        logic [L-1:0] ef;
        logic [L-1:0] ep;
        int c;
        int t;
        ent_t e;
        acc_seen = 1'b0;
        if (rst) begin
            chk("rst_out", {gamma_set, busy, edge_rise, edge_fall, pulse,
                            gamma_idx, in_ready}, 0);
            q.delete();
            act     = 1'b0;
            was_rst = 1'b1;
            n_acc   = 0;
            n_start = 0;
            return;
        end
        if (act && cyc >= s_cyc + G) act = 1'b0;
        if (!act && q.size() > 0 && int'(q[0].a) + 2 <= cyc) begin
            cur   = q.pop_front();
            s_cyc = cyc;
            act   = 1'b1;
            n_start++;
        end
        chk("in_ready", in_ready, !was_rst && q.size() == 0);
        was_rst = 1'b0;
        er = '0;
        ef = '0;
        ep = '0;
        c  = act ? cyc - s_cyc : 0;
        if (act) begin
            for (int i = 0; i < L; i++) begin
                t     = int'(cur.v[i*VW +: VW]);
                er[i] = (c >= t);
                ef[i] = (c < t);
                ep[i] = (c >= t) && (c < t + PW);
            end
        end
        chk("gamma_set", gamma_set, act && c == 0);
        chk("busy", busy, act);
        chk("gamma_idx", gamma_idx, c);
        chk("edge_rise", edge_rise, er);
        chk("edge_fall", edge_fall, ef);
        chk("pulse", pulse, ep);
        if (in_valid && in_ready) begin
            e.a = cyc;
            e.v = in_value;
            q.push_back(e);
            acc_seen = 1'b1;
            n_acc++;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input logic [VW-1:0] t1, input logic [VW-1:0] t0);
        in_valid = 1'b1;
        in_value = {t1, t0};
        for (int k = 0; k < 100; k++) begin
            tick();
            if (acc_seen) break;
        end
        if (!acc_seen) chk("send_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        int v;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_value = '0;
        cyc      = 0;
        s_cyc    = 0;
        checks   = 0;
        errors   = 0;
        n_acc    = 0;
        n_start  = 0;
        act      = 1'b0;
        acc_seen = 1'b0;
        was_rst  = 1'b0;
        #1;
        chk("rst_hold", {gamma_set, busy, edge_rise, edge_fall, pulse,
                         gamma_idx, in_ready}, 0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rdy_release", in_ready, 0);

        // single vector, truncation, boundary values
        send(5'd7, 5'd3);
        idle(20);
        send(5'd20, 5'd12);
        idle(20);
        send(5'd16, 5'd0);
        idle(20);

        // back-to-back gamma cycles
        send(5'd1, 5'd2);
        send(5'd31, 5'd9);
        idle(40);

        // async reset in the middle of a gamma cycle
        send(5'd4, 5'd5);
        for (int k = 0; k < 40; k++) begin
            if (act && cyc - s_cyc == 7) break;
            tick();
        end
        chk("mid_reached", act && cyc - s_cyc == 7, 1);
        #2;
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("async_clr", {gamma_set, busy, edge_rise, edge_fall, pulse,
                          gamma_idx, in_ready}, 0);
        tick();
        tick();
        rst = 1'b0;
        idle(25);

        // backpressure: valid held for 40 cycles with distinct values
        v = 0;
        for (int k = 0; k < 40; k++) begin
            in_valid = 1'b1;
            in_value = {VW'((v * 3) % 17), VW'(v % 16)};
            tick();
            if (acc_seen) v++;
        end
        idle(40);
        chk("bp_drain", q.size(), 0);
        chk("bp_count", n_start, n_acc);
        chk("bp_min_acc", n_acc >= 2, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
